// File: rtl/pr_swap_ctrl.sv
// ---------------------------------------------------------------------------
// pr_swap_ctrl
//
// Sequencer for partial reconfiguration of the `shift` and `count`
// reconfigurable modules (RMs). It sits between the RM outputs and the LED
// pins and drives the RM resets.
//
// A software swap request does the following, in order:
//   1. Freezes the LEDs (decouple).
//   2. Lets the RMs quiesce.
//   3. Pulses the configuration engine and waits for the load to finish.
//   4. Applies a clean RM reset.
//   5. Recouples the RM outputs and acknowledges.
// A load error or a load timeout parks the block in FAULT until a new
// request retries the load.
//
// Ports
//   clk, rst          : clock; synchronous active-high reset
//   swap_req          : swap request (rising edge is the request)
//   swap_ack          : one-cycle pulse on successful completion
//   swap_err          : high while in FAULT
//   busy              : high in every state except IDLE
//   state[2:0]        : current state encoding, for debug
//   pr_start          : one-cycle pulse to the configuration engine
//   pr_done, pr_error : load status from the configuration engine
//   rm_resetn         : active-low reset to both RMs
//   decouple          : high while RM outputs are isolated from the LEDs
//   rm_shift_in[3:0]  : `shift` RM data
//   rm_count_in[3:0]  : `count` RM data
//   shift_out[3:0]    : LEDs[3:0]
//   count_out[3:0]    : LEDs[7:4]
// ---------------------------------------------------------------------------
module pr_swap_ctrl #(
  parameter int unsigned QUIESCE_CYC = 16,
  parameter int unsigned RST_CYC     = 8,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       swap_err,
  output logic       busy,
  output logic [2:0] state,
  output logic       pr_start,
  input  logic       pr_done,
  input  logic       pr_error,
  output logic       rm_resetn,
  output logic       decouple,
  input  logic [3:0] rm_shift_in,
  input  logic [3:0] rm_count_in,
  output logic [3:0] shift_out,
  output logic [3:0] count_out
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_QUIESCE = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RESET   = 3'd3,
    ST_RELEASE = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  // One shared counter serves QUIESCE, LOAD and RESET. It is sized for the
  // largest of the three limits.
  localparam int unsigned CNT_M1  = (QUIESCE_CYC > RST_CYC) ? QUIESCE_CYC : RST_CYC;
  localparam int unsigned CNT_MAX = (CNT_M1 > TIMEOUT_CYC) ? CNT_M1 : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] QUIESCE_LIM = CNT_W'(QUIESCE_CYC);
  localparam logic [CNT_W-1:0] RST_LIM     = CNT_W'(RST_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             req_prev_q,  req_prev_d;
  logic             swap_ack_q,  swap_ack_d;
  logic             swap_err_q,  swap_err_d;
  logic             busy_q,      busy_d;
  logic             pr_start_q,  pr_start_d;
  logic             rm_resetn_q, rm_resetn_d;
  logic             decouple_q,  decouple_d;
  logic [3:0]       shift_out_q, shift_out_d;
  logic [3:0]       count_out_q, count_out_d;

  logic req_edge;

  // The edge-detect register resets to 1. A swap_req that is held high
  // through reset therefore does not count as a request.
  assign req_edge = swap_req & ~req_prev_q;

  // Next-state logic.
  // - Every counted state enters with the counter at 1 and leaves once the
  //   counter reaches its limit. The ">=" comparison still lets the FSM
  //   progress if the counter ever holds an out-of-range value.
  // - Every output is the registered image of the next state, so the
  //   outputs change on the same edge as the state does.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_prev_d  = swap_req;
    shift_out_d = shift_out_q;
    count_out_d = count_out_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_edge) begin
          state_d = ST_QUIESCE;
          cnt_d   = CNT_ONE;
        end
      end
      ST_QUIESCE: begin
        if (cnt_q >= QUIESCE_LIM) begin
          state_d = ST_LOAD;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_LOAD: begin
        // An error wins over a simultaneous done.
        if (pr_error) begin
          state_d = ST_FAULT;
        end else if (pr_done) begin
          state_d = ST_RESET;
          cnt_d   = CNT_ONE;
        end else if (cnt_q >= TIMEOUT_LIM) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RESET: begin
        if (cnt_q >= RST_LIM) begin
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        // A request in FAULT retries the load directly.
        if (req_edge) begin
          state_d = ST_LOAD;
          cnt_d   = CNT_ONE;
        end
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase

    // The LEDs follow the RMs only while coupled (IDLE). Otherwise they keep
    // the value registered on the last IDLE cycle.
    if (state_q == ST_IDLE) begin
      shift_out_d = rm_shift_in;
      count_out_d = rm_count_in;
    end

    busy_d      = (state_d != ST_IDLE);
    decouple_d  = (state_d != ST_IDLE);
    rm_resetn_d = (state_d == ST_IDLE) || (state_d == ST_QUIESCE) ||
                  (state_d == ST_RELEASE);
    swap_err_d  = (state_d == ST_FAULT);
    pr_start_d  = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    swap_ack_d  = (state_d == ST_IDLE) && (state_q == ST_RELEASE);
  end

  // State and output registers. Reset holds the RMs in reset and forces the
  // LEDs dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_prev_q  <= 1'b1;
      swap_ack_q  <= 1'b0;
      swap_err_q  <= 1'b0;
      busy_q      <= 1'b0;
      pr_start_q  <= 1'b0;
      rm_resetn_q <= 1'b0;
      decouple_q  <= 1'b0;
      shift_out_q <= 4'h0;
      count_out_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_prev_q  <= req_prev_d;
      swap_ack_q  <= swap_ack_d;
      swap_err_q  <= swap_err_d;
      busy_q      <= busy_d;
      pr_start_q  <= pr_start_d;
      rm_resetn_q <= rm_resetn_d;
      decouple_q  <= decouple_d;
      shift_out_q <= shift_out_d;
      count_out_q <= count_out_d;
    end
  end

  assign state     = state_q;
  assign swap_ack  = swap_ack_q;
  assign swap_err  = swap_err_q;
  assign busy      = busy_q;
  assign pr_start  = pr_start_q;
  assign rm_resetn = rm_resetn_q;
  assign decouple  = decouple_q;
  assign shift_out = shift_out_q;
  assign count_out = count_out_q;

endmodule

// File: tb/tb_pr_swap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pr_swap_ctrl
//
// Directed bench for pr_swap_ctrl.
// - Each stimulus step queues the cycle on which pr_start must pulse, and
//   the cycle and frozen LED values expected with swap_ack.
// - A negedge monitor pops those queues whenever the DUT raises pr_start or
//   swap_ack. An event that arrives with nothing queued is an error.
// - The main sequence also spot-checks state-level outputs at hand-computed
//   cycles. Cycle T is the cycle in which swap_req is high and is sampled.
// ---------------------------------------------------------------------------
module tb_pr_swap_ctrl;

  localparam int QUIESCE_CYC = 16;
  localparam int RST_CYC     = 8;
  localparam int TIMEOUT_CYC = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       swap_req;
  logic       swap_ack;
  logic       swap_err;
  logic       busy;
  logic [2:0] state;
  logic       pr_start;
  logic       pr_done;
  logic       pr_error;
  logic       rm_resetn;
  logic       decouple;
  logic [3:0] rm_shift_in;
  logic [3:0] rm_count_in;
  logic [3:0] shift_out;
  logic [3:0] count_out;

  typedef struct {
    int         cyc;
    logic [3:0] shift_v;
    logic [3:0] count_v;
  } ack_exp_t;

  ack_exp_t ack_q[$];
  int       start_q[$];

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  int t;

  pr_swap_ctrl #(
    .QUIESCE_CYC (QUIESCE_CYC),
    .RST_CYC     (RST_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .swap_err    (swap_err),
    .busy        (busy),
    .state       (state),
    .pr_start    (pr_start),
    .pr_done     (pr_done),
    .pr_error    (pr_error),
    .rm_resetn   (rm_resetn),
    .decouple    (decouple),
    .rm_shift_in (rm_shift_in),
    .rm_count_in (rm_count_in),
    .shift_out   (shift_out),
    .count_out   (count_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h",
               name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic done,
                               input logic err);
    swap_req = req;
    pr_done  = done;
    pr_error = err;
  endtask

  task automatic stepTo(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor for the pulse outputs.
  always @(negedge clk) begin
    if (!rst) begin
      if (pr_start === 1'b1) begin
        if (start_q.size() == 0) begin
          checkOutput("unexpected_pr_start", 32'(pr_start), 32'd0);
        end else begin
          checkOutput("pr_start_cycle", cyc, start_q.pop_front());
        end
      end
      if (swap_ack === 1'b1) begin
        if (ack_q.size() == 0) begin
          checkOutput("unexpected_swap_ack", 32'(swap_ack), 32'd0);
        end else begin
          ack_exp_t e;
          e = ack_q.pop_front();
          checkOutput("swap_ack_cycle", cyc, e.cyc);
          checkOutput("ack_shift_out", 32'(shift_out), 32'(e.shift_v));
          checkOutput("ack_count_out", 32'(count_out), 32'(e.count_v));
          checkOutput("ack_decouple", 32'(decouple), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset with swap_req held high.
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    rm_shift_in = 4'h3;
    rm_count_in = 4'h7;
    stepTo(3);
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_decouple", 32'(decouple), 32'd0);
    checkOutput("rst_rm_resetn", 32'(rm_resetn), 32'd0);
    checkOutput("rst_swap_ack", 32'(swap_ack), 32'd0);
    checkOutput("rst_swap_err", 32'(swap_err), 32'd0);
    checkOutput("rst_pr_start", 32'(pr_start), 32'd0);
    checkOutput("rst_shift_out", 32'(shift_out), 32'd0);
    checkOutput("rst_count_out", 32'(count_out), 32'd0);
    rst = 1'b0;
    stepTo(4);
    checkOutput("post_rst_rm_resetn", 32'(rm_resetn), 32'd1);
    checkOutput("post_rst_shift_out", 32'(shift_out), 32'h3);
    checkOutput("post_rst_count_out", 32'(count_out), 32'h7);
    stepTo(6);
    checkOutput("held_req_not_taken", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    rm_shift_in = 4'hA;
    rm_count_in = 4'hC;
    stepTo(8);

    // Nominal swap: pr_done 10 cycles after pr_start.
    t = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    start_q.push_back(t + 17);
    ack_q.push_back('{t + 37, 4'hA, 4'hC});
    stepTo(t + 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("nom_quiesce_state", 32'(state), 32'd1);
    checkOutput("nom_quiesce_decouple", 32'(decouple), 32'd1);
    checkOutput("nom_quiesce_busy", 32'(busy), 32'd1);
    checkOutput("nom_quiesce_rm_resetn", 32'(rm_resetn), 32'd1);
    stepTo(t + 16);
    checkOutput("nom_last_quiesce_state", 32'(state), 32'd1);
    stepTo(t + 17);
    checkOutput("nom_load_state", 32'(state), 32'd2);
    checkOutput("nom_load_rm_resetn", 32'(rm_resetn), 32'd0);
    rm_shift_in = 4'h5;
    rm_count_in = 4'h3;
    stepTo(t + 27);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepTo(t + 28);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("nom_reset_state", 32'(state), 32'd3);
    checkOutput("nom_frozen_shift", 32'(shift_out), 32'hA);
    stepTo(t + 35);
    checkOutput("nom_last_reset_rm_resetn", 32'(rm_resetn), 32'd0);
    stepTo(t + 36);
    checkOutput("nom_release_state", 32'(state), 32'd4);
    checkOutput("nom_release_rm_resetn", 32'(rm_resetn), 32'd1);
    checkOutput("nom_release_decouple", 32'(decouple), 32'd1);
    stepTo(t + 37);
    checkOutput("nom_ack_busy", 32'(busy), 32'd0);
    stepTo(t + 38);
    checkOutput("nom_new_shift", 32'(shift_out), 32'h5);
    checkOutput("nom_new_count", 32'(count_out), 32'h3);
    checkOutput("nom_ack_cleared", 32'(swap_ack), 32'd0);

    // Fast completion: pr_done on the first LOAD cycle.
    t = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    start_q.push_back(t + 17);
    ack_q.push_back('{t + 27, 4'h5, 4'h3});
    stepTo(t + 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepTo(t + 17);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepTo(t + 18);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepTo(t + 26);
    checkOutput("fast_release_state", 32'(state), 32'd4);
    stepTo(t + 29);

    // pr_done and pr_error together: error wins.
    t = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    start_q.push_back(t + 17);
    stepTo(t + 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepTo(t + 17);
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepTo(t + 18);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("prio_fault_state", 32'(state), 32'd5);
    checkOutput("prio_swap_err", 32'(swap_err), 32'd1);
    checkOutput("prio_rm_resetn", 32'(rm_resetn), 32'd0);
    checkOutput("prio_decouple", 32'(decouple), 32'd1);
    stepTo(t + 22);
    checkOutput("prio_swap_err_held", 32'(swap_err), 32'd1);

    // Retry from FAULT, completing normally.
    t = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    start_q.push_back(t + 1);
    ack_q.push_back('{t + 13, 4'h5, 4'h3});
    stepTo(t + 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("retry_load_state", 32'(state), 32'd2);
    checkOutput("retry_swap_err", 32'(swap_err), 32'd0);
    rm_shift_in = 4'h9;
    rm_count_in = 4'h6;
    stepTo(t + 3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepTo(t + 4);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepTo(t + 14);
    checkOutput("retry_new_shift", 32'(shift_out), 32'h9);
    checkOutput("retry_new_count", 32'(count_out), 32'h6);

    // Timeout: no pr_done, FAULT after TIMEOUT_CYC LOAD cycles.
    t = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    start_q.push_back(t + 17);
    stepTo(t + 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepTo(t + 36);
    checkOutput("tmo_last_load_state", 32'(state), 32'd2);
    stepTo(t + 37);
    checkOutput("tmo_fault_state", 32'(state), 32'd5);
    checkOutput("tmo_swap_err", 32'(swap_err), 32'd1);
    stepTo(t + 40);
    checkOutput("tmo_decouple", 32'(decouple), 32'd1);
    checkOutput("tmo_rm_resetn", 32'(rm_resetn), 32'd0);

    // Retry with pr_done on the first LOAD cycle.
    t = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    start_q.push_back(t + 1);
    ack_q.push_back('{t + 11, 4'h9, 4'h6});
    stepTo(t + 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepTo(t + 2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepTo(t + 13);

    // Request edges in QUIESCE and LOAD are dropped.
    t = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    start_q.push_back(t + 17);
    ack_q.push_back('{t + 27, 4'h9, 4'h6});
    stepTo(t + 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepTo(t + 4);
    applyStimulus(1'b1, 1'b0, 1'b0);
    stepTo(t + 5);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepTo(t + 17);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepTo(t + 18);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepTo(t + 32);
    checkOutput("drop_idle_state", 32'(state), 32'd0);
    checkOutput("drop_idle_busy", 32'(busy), 32'd0);

    // rst during RESET aborts without swap_ack.
    t = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    start_q.push_back(t + 17);
    stepTo(t + 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepTo(t + 17);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepTo(t + 18);
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepTo(t + 20);
    checkOutput("abort_pre_state", 32'(state), 32'd3);
    rst = 1'b1;
    stepTo(t + 21);
    rst = 1'b0;
    checkOutput("abort_state", 32'(state), 32'd0);
    checkOutput("abort_decouple", 32'(decouple), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_rm_resetn", 32'(rm_resetn), 32'd0);
    stepTo(t + 22);
    checkOutput("abort_rm_resetn_release", 32'(rm_resetn), 32'd1);
    stepTo(t + 35);
    checkOutput("abort_still_idle", 32'(state), 32'd0);

    checkOutput("pending_pr_start", 32'(start_q.size()), 32'd0);
    checkOutput("pending_swap_ack", 32'(ack_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
